multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM for the 16-bit processor datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the register enables (IR, PC, MAR, FLAGS), the mux selects and the ALU function.
- Handles a memory ready/wait handshake and raises a bus error when memory does not respond in time.

---
 rtl/multicycle_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 16-bit datapath.
// Steps each instruction through fetch, decode, execute and an optional
// memory phase. It also enforces a bounded wait on the memory handshake.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// FETCH_ADDR | idle/first fetch cycle; load MAR from PC when run=1
// FETCH_MEM  | instruction read in flight; load IR and PC+1 on mem_ready
// DECODE     | latch the opcode from IR
// EXEC       | drive ALU/branch controls, or set up the data address
// MEM        | data read (LOAD) or write (STORE) in flight
// HALT       | stopped by a HALT opcode or a bus timeout; left only by reset
module multicycle_sequencer #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_FUNC_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [OPCODE_W-1:0]   ir_opcode,
  input  logic                  flag_z,
  input  logic                  mem_ready,
  output logic                  ir_en,
  output logic                  pc_en,
  output logic                  pc_sel,
  output logic                  mar_en,
  output logic                  mar_sel,
  output logic                  immed_sel,
  output logic [ALU_FUNC_W-1:0] alu_func,
  output logic                  w_en,
  output logic                  mem_sel,
  output logic                  flag_en,
  output logic                  mem_en,
  output logic                  rw,
  output logic                  halted,
  output logic                  illegal,
  output logic                  bus_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_XOR   = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] OP_SHL   = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] OP_SHR   = OPCODE_W'(4'h7);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(4'h8);
  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(4'h9);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(4'hA);
  localparam logic [OPCODE_W-1:0] OP_BRZ   = OPCODE_W'(4'hB);
  localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(4'hC);
  localparam logic [OPCODE_W-1:0] OP_ILL_D = OPCODE_W'(4'hD);
  localparam logic [OPCODE_W-1:0] OP_ILL_E = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(4'hF);

  typedef enum logic [2:0] {
    S_FETCH_ADDR,
    S_FETCH_MEM,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bus_err_q, bus_err_d;
  logic                waiting;
  logic                timeout;

  assign waiting = (state_q == S_FETCH_MEM) || (state_q == S_MEM);
  // The wait on cycle MEM_TIMEOUT still accepts a ready; only a miss there times out.
  assign timeout = waiting && !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT));

  // Next-state, wait counter and control decode; outputs are forced low while reset is held.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    bus_err_d = bus_err_q;
    cnt_d     = (waiting && !mem_ready && !timeout) ? cnt_q + CNT_W'(1) : '0;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 1'b0;
    mar_en    = 1'b0;
    mar_sel   = 1'b0;
    immed_sel = 1'b0;
    alu_func  = '0;
    w_en      = 1'b0;
    mem_sel   = 1'b0;
    flag_en   = 1'b0;
    mem_en    = 1'b0;
    rw        = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      S_FETCH_ADDR: begin
        if (run) begin
          mar_en  = 1'b1;
          mar_sel = 1'b1;
          state_d = S_FETCH_MEM;
        end
      end
      S_FETCH_MEM: begin
        mem_en = 1'b1;
        if (mem_ready) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          pc_sel  = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_DECODE: begin
        opcode_d = ir_opcode;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH_ADDR;
        case (opcode_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            w_en     = 1'b1;
            flag_en  = 1'b1;
            alu_func = ALU_FUNC_W'(opcode_q - OP_ADD);
          end
          OP_ADDI: begin
            w_en      = 1'b1;
            flag_en   = 1'b1;
            immed_sel = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            mar_en    = 1'b1;
            immed_sel = 1'b1;
            state_d   = S_MEM;
          end
          OP_BRZ: begin
            pc_en     = flag_z;
            immed_sel = 1'b1;
          end
          OP_JMP: begin
            pc_en     = 1'b1;
            immed_sel = 1'b1;
          end
          OP_HALT:            state_d = S_HALT;
          OP_ILL_D, OP_ILL_E: illegal = 1'b1;
          default:            ;
        endcase
      end
      S_MEM: begin
        mem_en = 1'b1;
        rw     = (opcode_q == OP_STORE);
        if (mem_ready) begin
          if (opcode_q == OP_LOAD) begin
            w_en    = 1'b1;
            mem_sel = 1'b1;
          end
          state_d = S_FETCH_ADDR;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_FETCH_ADDR;
    endcase
    // run is live in FETCH_ADDR, so gating keeps everything quiet during reset.
    if (!reset) begin
      ir_en     = 1'b0;
      pc_en     = 1'b0;
      pc_sel    = 1'b0;
      mar_en    = 1'b0;
      mar_sel   = 1'b0;
      immed_sel = 1'b0;
      alu_func  = '0;
      w_en      = 1'b0;
      mem_sel   = 1'b0;
      flag_en   = 1'b0;
      mem_en    = 1'b0;
      rw        = 1'b0;
      halted    = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign bus_err = bus_err_q;

  // State, opcode latch, wait counter and sticky bus error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH_ADDR;
      opcode_q  <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer. Stimulus pushes the expected
// control vector for every cycle it drives. A monitor pops and compares
// that vector on the falling edge.
module tb_multicycle_sequencer;

  // Bit positions in the packed control vector.
  localparam logic [17:0] IR   = 18'h1 << 17;
  localparam logic [17:0] PCE  = 18'h1 << 16;
  localparam logic [17:0] PCS  = 18'h1 << 15;
  localparam logic [17:0] MARE = 18'h1 << 14;
  localparam logic [17:0] MARS = 18'h1 << 13;
  localparam logic [17:0] IMM  = 18'h1 << 12;
  localparam logic [17:0] WEN  = 18'h1 << 7;
  localparam logic [17:0] MSEL = 18'h1 << 6;
  localparam logic [17:0] FEN  = 18'h1 << 5;
  localparam logic [17:0] MEN  = 18'h1 << 4;
  localparam logic [17:0] RW   = 18'h1 << 3;
  localparam logic [17:0] HLT  = 18'h1 << 2;
  localparam logic [17:0] ILL  = 18'h1 << 1;
  localparam logic [17:0] BERR = 18'h1 << 0;
  localparam logic [17:0] NONE = 18'h0;

  function automatic logic [17:0] alu(input int f);
    return 18'(f) << 8;
  endfunction

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b1;
  logic [3:0] ir_opcode = 4'h0;
  logic       flag_z = 1'b0;
  logic       mem_ready = 1'b1;
  logic       ir_en, pc_en, pc_sel, mar_en, mar_sel, immed_sel;
  logic [3:0] alu_func;
  logic       w_en, mem_sel, flag_en, mem_en, rw, halted, illegal, bus_err;

  int total = 0;
  int bad = 0;
  logic [17:0] exp_q[$];
  string       name_q[$];

  multicycle_sequencer #(.OPCODE_W(4), .ALU_FUNC_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run), .ir_opcode(ir_opcode),
    .flag_z(flag_z), .mem_ready(mem_ready),
    .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .mar_en(mar_en),
    .mar_sel(mar_sel), .immed_sel(immed_sel), .alu_func(alu_func),
    .w_en(w_en), .mem_sel(mem_sel), .flag_en(flag_en), .mem_en(mem_en),
    .rw(rw), .halted(halted), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle the DUT presents a control vector; check it against the scoreboard.
  initial begin
    logic [17:0] act, e;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = {ir_en, pc_en, pc_sel, mar_en, mar_sel, immed_sel, alu_func,
               w_en, mem_sel, flag_en, mem_en, rw, halted, illegal, bus_err};
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s: got %05h want %05h", nm, act, e);
        end
      end
    end
  end

  // One clock cycle of stimulus plus its expected control vector.
  task automatic cyc(input logic r, input logic rn, input logic [3:0] op,
                     input logic fz, input logic rdy, input logic [17:0] e,
                     input string nm);
    @(posedge clk);
    #1;
    reset = r; run = rn; ir_opcode = op; flag_z = fz; mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // FETCH_ADDR, FETCH_MEM (ready at once), DECODE of op.
  task automatic fetch(input logic [3:0] op, input string nm);
    cyc(1, 1, 4'h0, 0, 1, MARE | MARS, {nm, " fetch_addr"});
    cyc(1, 1, 4'h0, 0, 1, MEN | IR | PCE | PCS, {nm, " fetch_mem"});
    cyc(1, 1, op, 0, 1, NONE, {nm, " decode"});
  endtask

  task automatic one_instr(input logic [3:0] op, input logic fz,
                           input logic [17:0] e, input string nm);
    fetch(op, nm);
    cyc(1, 1, 4'h0, fz, 1, e, {nm, " exec"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset held with run=1: all quiet.
    cyc(0, 1, 4'h0, 0, 1, NONE, "reset0");
    cyc(0, 1, 4'h0, 0, 1, NONE, "reset1");

    // ALU ops, each with a 4-cycle best case (next fetch_addr follows exec).
    one_instr(4'h1, 0, alu(0) | WEN | FEN, "add");
    one_instr(4'h2, 0, alu(1) | WEN | FEN, "sub");
    one_instr(4'h3, 0, alu(2) | WEN | FEN, "and");
    one_instr(4'h5, 0, alu(4) | WEN | FEN, "xor");
    one_instr(4'h7, 0, alu(6) | WEN | FEN, "shr");
    one_instr(4'h8, 0, IMM | WEN | FEN, "addi");
    one_instr(4'h0, 0, NONE, "nop");

    // LOAD with three stall cycles in MEM.
    one_instr(4'h9, 0, MARE | IMM, "load");
    cyc(1, 1, 4'h0, 0, 0, MEN, "load wait1");
    cyc(1, 1, 4'h0, 0, 0, MEN, "load wait2");
    cyc(1, 1, 4'h0, 0, 0, MEN, "load wait3");
    cyc(1, 1, 4'h0, 0, 1, MEN | WEN | MSEL, "load done");

    // STORE with one stall cycle.
    one_instr(4'hA, 0, MARE | IMM, "store");
    cyc(1, 1, 4'h0, 0, 0, MEN | RW, "store wait");
    cyc(1, 1, 4'h0, 0, 1, MEN | RW, "store done");

    // Branches.
    one_instr(4'hB, 0, IMM, "brz nz");
    one_instr(4'hB, 1, PCE | IMM, "brz z");
    one_instr(4'hC, 0, PCE | IMM, "jmp");

    // run=0 holds in FETCH_ADDR.
    cyc(1, 0, 4'h0, 0, 1, NONE, "run0 a");
    cyc(1, 0, 4'h0, 0, 1, NONE, "run0 b");

    // Illegal opcodes pulse for one cycle, then a normal fetch.
    one_instr(4'hE, 0, ILL, "ill e");
    one_instr(4'hD, 0, ILL, "ill d");

    // Ready on wait cycle 15 is still accepted.
    cyc(1, 1, 4'h0, 0, 1, MARE | MARS, "late fetch_addr");
    for (int i = 0; i < 15; i++) cyc(1, 1, 4'h0, 0, 0, MEN, "late wait");
    cyc(1, 1, 4'h0, 0, 1, MEN | IR | PCE | PCS, "late accept");
    cyc(1, 1, 4'h4, 0, 1, NONE, "late decode");
    cyc(1, 1, 4'h0, 0, 1, alu(3) | WEN | FEN, "late or exec");

    // Reset in the middle of a data access drops mem_en at once.
    one_instr(4'h9, 0, MARE | IMM, "mid load");
    cyc(1, 1, 4'h0, 0, 0, MEN, "mid wait");
    cyc(0, 1, 4'h0, 0, 0, NONE, "mid reset");

    // HALT stays through 20 cycles with run=1.
    one_instr(4'hF, 0, NONE, "halt");
    for (int i = 0; i < 20; i++) cyc(1, 1, 4'h0, 0, 1, HLT, "halted");
    cyc(0, 1, 4'h0, 0, 1, NONE, "halt reset");
    one_instr(4'h6, 0, alu(5) | WEN | FEN, "shl after halt");

    // Fetch timeout: 16 cycles without ready, then HALT with bus error.
    cyc(1, 1, 4'h0, 0, 0, MARE | MARS, "to fetch_addr");
    for (int i = 0; i < 16; i++) cyc(1, 1, 4'h0, 0, 0, MEN, "to wait");
    cyc(1, 1, 4'h0, 0, 0, HLT | BERR, "to halt");
    cyc(1, 1, 4'h0, 0, 1, HLT | BERR, "to sticky");
    cyc(0, 1, 4'h0, 0, 1, NONE, "to reset");
    one_instr(4'h1, 0, alu(0) | WEN | FEN, "add after timeout");

    // Let the monitor drain the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
